// File: rtl/nlc_horner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nlc_horner_sequencer
//  Purpose  : Sequences one 5th-order Horner evaluation per request,
//             y = ((((a5*x + a4)*x + a3)*x + a2)*x + a1)*x + a0,
//             through one shared FP32 multiplier and one shared FP32 adder
//             using their srdyi/srdyo handshakes. No arithmetic is done
//             here; every value passes through bit-exact.
//  Ports    : clk, rst (async, active-low)
//             srdyi, x_i, ch_i          request from the normalization stage
//             busy, srdyo, y_o, ch_o    status and result to the converter
//             ovr_err                   sticky: request dropped while busy
//             coeff_ch_o, coeff_idx_o,
//             coeff_i                   combinational coefficient lookup
//             mul_* / add_*             shared arithmetic unit handshakes
//  Revision : 1.0  initial release
// ============================================================================
module nlc_horner_sequencer #(
    parameter int CH_NUM = 16,
    parameter int W      = 32,
    localparam int CH_W  = $clog2(CH_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            srdyi,
    input  logic [W-1:0]    x_i,
    input  logic [CH_W-1:0] ch_i,
    output logic            busy,
    output logic            srdyo,
    output logic [W-1:0]    y_o,
    output logic [CH_W-1:0] ch_o,
    output logic            ovr_err,
    output logic [CH_W-1:0] coeff_ch_o,
    output logic [2:0]      coeff_idx_o,
    input  logic [W-1:0]    coeff_i,
    output logic            mul_srdyi,
    output logic [W-1:0]    mul_in1,
    output logic [W-1:0]    mul_in2,
    input  logic            mul_srdyo,
    input  logic [W-1:0]    mul_out,
    output logic            add_srdyi,
    output logic [W-1:0]    add_in1,
    output logic [W-1:0]    add_in2,
    input  logic            add_srdyo,
    input  logic [W-1:0]    add_out
);

    localparam logic [2:0] C_IDX_A5 = 3'd5;
    localparam logic [2:0] C_IDX_A4 = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_ISSUE = 3'd1,
        S_MUL_WAIT  = 3'd2,
        S_ADD_ISSUE = 3'd3,
        S_ADD_WAIT  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_k, w_k_nxt;
    logic [CH_W-1:0] r_ch, w_ch_nxt;

    logic            w_mul_srdyi_nxt, w_add_srdyi_nxt, w_srdyo_nxt, w_ovr_nxt;
    logic [W-1:0]    w_mul_in1_nxt, w_mul_in2_nxt;
    logic [W-1:0]    w_add_in1_nxt, w_add_in2_nxt;
    logic [W-1:0]    w_y_nxt;
    logic [CH_W-1:0] w_ch_o_nxt;

    // mul_in1 doubles as the accumulator and add_in1 as the product
    // register: each is loaded exactly when the value it carries is
    // produced, and the units only look at them on their issue pulse.
    // mul_in2 carries x for the whole evaluation.

    assign busy = (r_state != S_IDLE);

    // While idle the lookup is pointed at a5 of the incoming channel so the
    // request cycle can capture it directly. While busy, r_k names the
    // coefficient the next add needs; add_in2 is captured from coeff_i on
    // the same edge that accepts the multiplier result.
    assign coeff_ch_o  = (r_state == S_IDLE) ? ch_i     : r_ch;
    assign coeff_idx_o = (r_state == S_IDLE) ? C_IDX_A5 : r_k;

    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_ch_nxt        = r_ch;
        w_mul_srdyi_nxt = 1'b0;
        w_mul_in1_nxt   = mul_in1;
        w_mul_in2_nxt   = mul_in2;
        w_add_srdyi_nxt = 1'b0;
        w_add_in1_nxt   = add_in1;
        w_add_in2_nxt   = add_in2;
        w_srdyo_nxt     = 1'b0;
        w_y_nxt         = y_o;
        w_ch_o_nxt      = ch_o;
        // A request arriving while busy is dropped and flagged.
        w_ovr_nxt       = ovr_err | (srdyi & (r_state != S_IDLE));

        case (r_state)
            S_IDLE: begin
                if (srdyi) begin
                    w_ch_nxt        = ch_i;
                    w_k_nxt         = C_IDX_A4;
                    w_mul_srdyi_nxt = 1'b1;
                    w_mul_in1_nxt   = coeff_i;
                    w_mul_in2_nxt   = x_i;
                    w_state_nxt     = S_MUL_ISSUE;
                end
            end
            S_MUL_ISSUE: begin
                w_state_nxt = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mul_srdyo) begin
                    w_add_srdyi_nxt = 1'b1;
                    w_add_in1_nxt   = mul_out;
                    w_add_in2_nxt   = coeff_i;
                    w_state_nxt     = S_ADD_ISSUE;
                end
            end
            S_ADD_ISSUE: begin
                w_state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (add_srdyo) begin
                    if (r_k == 3'd0) begin
                        // The result is published on this edge, so srdyo is
                        // seen while the FSM is already back in IDLE and a
                        // request in that same cycle is accepted. This edge
                        // is the completion step; S_DONE is not occupied.
                        w_y_nxt     = add_out;
                        w_ch_o_nxt  = r_ch;
                        w_srdyo_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_k_nxt         = r_k - 3'd1;
                        w_mul_srdyi_nxt = 1'b1;
                        w_mul_in1_nxt   = add_out;
                        w_state_nxt     = S_MUL_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_k       <= 3'd0;
            r_ch      <= '0;
            mul_srdyi <= 1'b0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            add_srdyi <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
            srdyo     <= 1'b0;
            y_o       <= '0;
            ch_o      <= '0;
            ovr_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_ch      <= w_ch_nxt;
            mul_srdyi <= w_mul_srdyi_nxt;
            mul_in1   <= w_mul_in1_nxt;
            mul_in2   <= w_mul_in2_nxt;
            add_srdyi <= w_add_srdyi_nxt;
            add_in1   <= w_add_in1_nxt;
            add_in2   <= w_add_in2_nxt;
            srdyo     <= w_srdyo_nxt;
            y_o       <= w_y_nxt;
            ch_o      <= w_ch_o_nxt;
            ovr_err   <= w_ovr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nlc_horner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nlc_horner_sequencer
//  Purpose  : Self-checking bench for nlc_horner_sequencer. Provides a
//             coefficient bank, latency-programmable multiplier/adder unit
//             models and a per-cycle reference model of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nlc_horner_sequencer;

    logic        clk;
    logic        rst;
    logic        srdyi;
    logic [31:0] x_i;
    logic [3:0]  ch_i;
    logic        busy, srdyo, ovr_err;
    logic [31:0] y_o;
    logic [3:0]  ch_o, coeff_ch_o;
    logic [2:0]  coeff_idx_o;
    logic [31:0] coeff_i;
    logic        mul_srdyi, add_srdyi;
    logic [31:0] mul_in1, mul_in2, add_in1, add_in2;
    logic        mul_srdyo, add_srdyo;
    logic [31:0] mul_out, add_out;

    logic        mul_srdyo_u, add_srdyo_u, spur_mul, spur_add;
    assign mul_srdyo = mul_srdyo_u | spur_mul;
    assign add_srdyo = add_srdyo_u | spur_add;

    logic [31:0] bank [16][6];
    assign coeff_i = (coeff_idx_o < 3'd6) ? bank[coeff_ch_o][coeff_idx_o] : 32'h0;

    int  lm_cfg, la_cfg;
    bit  fp_mode;
    int  errors, checks;
    int  cyc;
    int  srdyo_cnt;
    logic [2:0] idx_seq[$];

    nlc_horner_sequencer dut (
        .clk(clk), .rst(rst), .srdyi(srdyi), .x_i(x_i), .ch_i(ch_i),
        .busy(busy), .srdyo(srdyo), .y_o(y_o), .ch_o(ch_o), .ovr_err(ovr_err),
        .coeff_ch_o(coeff_ch_o), .coeff_idx_o(coeff_idx_o), .coeff_i(coeff_i),
        .mul_srdyi(mul_srdyi), .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_srdyo(mul_srdyo), .mul_out(mul_out),
        .add_srdyi(add_srdyi), .add_in1(add_in1), .add_in2(add_in2),
        .add_srdyo(add_srdyo), .add_out(add_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- arithmetic used by the unit models ----------------
    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0)   return {d[63], 31'h0};
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // Non-commutative mixing functions make operand swaps visible.
    function automatic logic [31:0] umul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        if (fp_mode) return r2f(f2r(a) * f2r(b));
        p = a * 32'h9E3779B1;
        return p ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [31:0] uadd(input logic [31:0] a, input logic [31:0] b);
        if (fp_mode) return r2f(f2r(a) + f2r(b));
        return a + {b[30:0], 1'b0} + 32'd1;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 129)), 23'($urandom)};
    endfunction

    // ---------------- unit models (drive on the falling edge) ----------------
    int mul_cnt, add_cnt;
    logic [31:0] mul_res, add_res;
    initial begin
        mul_cnt = 0; add_cnt = 0; mul_srdyo_u = 1'b0; add_srdyo_u = 1'b0;
        mul_out = 32'h0; add_out = 32'h0; mul_res = 32'h0; add_res = 32'h0;
    end
    always @(negedge clk) begin
        mul_srdyo_u = 1'b0;
        add_srdyo_u = 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin mul_srdyo_u = 1'b1; mul_out = mul_res; end
        end
        if (add_cnt > 0) begin
            add_cnt--;
            if (add_cnt == 0) begin add_srdyo_u = 1'b1; add_out = add_res; end
        end
        if (mul_srdyi) begin mul_res = umul(mul_in1, mul_in2); mul_cnt = lm_cfg; end
        if (add_srdyi) begin add_res = uadd(add_in1, add_in2); add_cnt = la_cfg; end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_act;
    int          m_acc, m_due, m_lm, m_la;
    logic [31:0] m_x, m_y;
    logic [3:0]  m_ch;
    logic [31:0] em1 [5];
    logic [31:0] ea1 [5];
    logic [31:0] ea2 [5];
    logic [31:0] e_y, e_m1, e_m2, e_a1, e_a2;
    logic [3:0]  e_ch;
    bit          e_ovr;

    task automatic start_model(input int c);
        logic [31:0] acc, p;
        m_act = 1'b1;
        m_acc = c;
        m_lm  = lm_cfg;
        m_la  = la_cfg;
        m_due = c + 1 + 5 * (lm_cfg + 1) + 5 * (la_cfg + 1);
        m_x   = x_i;
        m_ch  = ch_i;
        acc   = bank[ch_i][5];
        for (int j = 0; j < 5; j++) begin
            em1[j] = acc;
            p      = umul(acc, x_i);
            ea1[j] = p;
            ea2[j] = bank[ch_i][4 - j];
            acc    = uadd(p, bank[ch_i][4 - j]);
        end
        m_y = acc;
    endtask

    initial begin
        cyc = 0; srdyo_cnt = 0; m_act = 1'b0; m_acc = 0; m_due = 0;
        m_lm = 1; m_la = 1; m_x = 0; m_y = 0; m_ch = 0;
        e_y = 0; e_m1 = 0; e_m2 = 0; e_a1 = 0; e_a2 = 0; e_ch = 0; e_ovr = 1'b0;
    end

    always @(posedge clk) begin
        int  per, d, da;
        bit  busy_e, mul_e, add_e, srdyo_e;
        #1;
        cyc++;
        if (!rst) begin
            m_act = 1'b0;
            e_y = 0; e_ch = 0; e_ovr = 1'b0;
            e_m1 = 0; e_m2 = 0; e_a1 = 0; e_a2 = 0;
        end else if (srdyi) begin
            if (m_act && (m_acc < cyc - 1) && (cyc - 1 < m_due)) e_ovr = 1'b1;
            else start_model(cyc - 1);
        end
        per    = m_lm + m_la + 2;
        d      = cyc - m_acc - 1;
        da     = d - (m_lm + 1);
        busy_e = m_act && (cyc > m_acc) && (cyc < m_due);
        mul_e  = busy_e && (d % per == 0) && (d / per < 5);
        add_e  = busy_e && (da >= 0) && (da % per == 0) && (da / per < 5);
        srdyo_e = m_act && (cyc == m_due);
        if (mul_e) begin e_m1 = em1[d / per]; e_m2 = m_x; end
        if (add_e) begin e_a1 = ea1[da / per]; e_a2 = ea2[da / per]; end
        if (srdyo_e) begin e_y = m_y; e_ch = m_ch; end
        chk("busy", 32'(busy), 32'(busy_e));
        chk("srdyo", 32'(srdyo), 32'(srdyo_e));
        chk("y_o", y_o, e_y);
        chk("ch_o", 32'(ch_o), 32'(e_ch));
        chk("ovr_err", 32'(ovr_err), 32'(e_ovr));
        chk("mul_srdyi", 32'(mul_srdyi), 32'(mul_e));
        chk("add_srdyi", 32'(add_srdyi), 32'(add_e));
        chk("mul_in1", mul_in1, e_m1);
        chk("mul_in2", mul_in2, e_m2);
        chk("add_in1", add_in1, e_a1);
        chk("add_in2", add_in2, e_a2);
        chk("coeff_idx_o", 32'(coeff_idx_o), busy_e ? 32'(4 - d / per) : 32'd5);
        chk("coeff_ch_o", 32'(coeff_ch_o), busy_e ? 32'(m_ch) : 32'(ch_i));
        if (srdyo) srdyo_cnt++;
    end

    // ---------------- stimulus ----------------
    // Issues one request and waits for srdyo; returns at posedge+1 of the
    // srdyo cycle. Pulse helpers fire at iteration n (= cycles after srdyi).
    task automatic req_collect(input logic [31:0] x, input logic [3:0] ch,
                               input int ovr_n, input int spm_n, input int spa_n,
                               output int lat);
        @(negedge clk);
        x_i = x; ch_i = ch; srdyi = 1'b1;
        #1;
        idx_seq.delete();
        idx_seq.push_back(coeff_idx_o);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (srdyo) begin lat = n; break; end
            if (coeff_idx_o != idx_seq[idx_seq.size() - 1]) idx_seq.push_back(coeff_idx_o);
            @(negedge clk);
            srdyi    = (n == ovr_n);
            spur_mul = (n == spm_n);
            spur_add = (n == spa_n);
        end
        srdyi = 1'b0; spur_mul = 1'b0; spur_add = 1'b0;
        if (lat < 0) chk("srdyo_timeout", 32'd0, 32'd1);
    endtask

    int lat, cnt0;

    initial begin
        errors = 0; checks = 0;
        rst = 1'b0; srdyi = 1'b0; x_i = 32'h0; ch_i = 4'h0;
        spur_mul = 1'b0; spur_add = 1'b0;
        fp_mode = 1'b1; lm_cfg = 1; la_cfg = 1;
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 6; k++) bank[c][k] = rand_fp();
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_y_o", y_o, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-ones coefficients, x=2.0 -> 63.0 after 21 cycles.
        for (int k = 0; k < 6; k++) bank[3][k] = 32'h3F800000;
        req_collect(32'h40000000, 4'd3, -1, -1, -1, lat);
        chk("t1_latency", 32'(lat), 32'd21);
        chk("t1_y", y_o, 32'h427C0000);
        chk("t1_ch", 32'(ch_o), 32'd3);
        chk("t1_idx_len", 32'(idx_seq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < idx_seq.size()) chk("t1_idx_seq", 32'(idx_seq[i]), 32'(5 - i));

        // x=0 -> a0, Lm=3 La=2, with misplaced unit pulses that must be ignored.
        repeat (2) @(posedge clk);
        lm_cfg = 3; la_cfg = 2;
        bank[5][0] = 32'h40400000;
        req_collect(32'h00000000, 4'd5, -1, 7, 2, lat);
        chk("t2_latency", 32'(lat), 32'd36);
        chk("t2_y", y_o, 32'h40400000);

        // Spurious unit pulses while idle.
        fp_mode = 1'b0; lm_cfg = 1; la_cfg = 1;
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 6; k++) bank[c][k] = $urandom;
        cnt0 = srdyo_cnt;
        @(negedge clk); spur_mul = 1'b1; spur_add = 1'b1;
        @(negedge clk); spur_mul = 1'b0; spur_add = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_srdyo_cnt", 32'(srdyo_cnt - cnt0), 32'd0);

        // Overrun: second request 5 cycles after an accepted one.
        cnt0 = srdyo_cnt;
        req_collect($urandom, 4'd7, 5, -1, -1, lat);
        repeat (30) @(negedge clk);
        chk("t3_ovr_err", 32'(ovr_err), 32'd1);
        chk("t3_one_srdyo", 32'(srdyo_cnt - cnt0), 32'd1);

        // Reset during ADD_WAIT of the third add, late add_srdyo afterwards.
        lm_cfg = 1; la_cfg = 3;
        cnt0 = srdyo_cnt;
        @(negedge clk); x_i = $urandom; ch_i = 4'd9; srdyi = 1'b1;
        @(negedge clk); srdyi = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_y_o", y_o, 32'h0);
        chk("t4_ch_o", 32'(ch_o), 32'd0);
        chk("t4_ovr_err", 32'(ovr_err), 32'd0);
        chk("t4_no_srdyo", 32'(srdyo_cnt - cnt0), 32'd0);

        // Back-to-back ch0 then ch15, second request in the srdyo cycle.
        lm_cfg = 2; la_cfg = 1;
        req_collect($urandom, 4'd0, -1, -1, -1, lat);
        chk("t5_ch_first", 32'(ch_o), 32'd0);
        req_collect($urandom, 4'd15, -1, -1, -1, lat);
        chk("t5_ch_second", 32'(ch_o), 32'd15);
        chk("t5_ovr_err", 32'(ovr_err), 32'd0);

        // Randomized requests, latencies, gaps and overrun attempts.
        for (int i = 0; i < 20; i++) begin
            lm_cfg = $urandom_range(1, 4);
            la_cfg = $urandom_range(1, 4);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            req_collect($urandom, 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : -1,
                        -1, -1, lat);
            chk("rand_latency", 32'(lat), 32'(1 + 5 * (lm_cfg + 1) + 5 * (la_cfg + 1)));
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
